// File: rtl/avalon_mm_timeout_bridge.sv
// avalon_mm_timeout_bridge: single-outstanding Avalon-MM bridge with a response watchdog and timeout counter
module avalon_mm_timeout_bridge #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   s_address,
  input  logic                s_read,
  input  logic                s_write,
  input  logic [DATA_W/8-1:0] s_byteenable,
  input  logic [DATA_W-1:0]   s_writedata,
  output logic                s_waitrequest,
  output logic [DATA_W-1:0]   s_readdata,
  output logic                s_readdatavalid,
  output logic                s_writeresponsevalid,
  output logic [1:0]          s_response,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  input  logic                m_writeresponsevalid,
  input  logic [1:0]          m_response,
  output logic [15:0]         timeout_cnt,
  input  logic                timeout_cnt_clr
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, FLUSH} state_t;
  state_t state, next_state;
  logic [TW-1:0] timer;
  logic is_wr, op_wr, cap, rsp_hit, tmo, flush_done, fire;
  always_comb begin
    cap = state == IDLE && !s_waitrequest && (s_read || s_write);
    op_wr = cap ? s_write : is_wr;
    rsp_hit = state == WAIT_RSP && (is_wr ? m_writeresponsevalid : m_readdatavalid);
    tmo = (state == ISSUE || state == WAIT_RSP) && timer == T_LAST && !rsp_hit;
    flush_done = state == FLUSH && (m_readdatavalid || m_writeresponsevalid || timer == T_LAST);
    fire = rsp_hit || tmo;
    next_state = state;
    case (state)
      IDLE:     next_state = cap ? ISSUE : IDLE;
      ISSUE:    next_state = tmo ? FLUSH : (m_waitrequest ? ISSUE : WAIT_RSP);
      WAIT_RSP: next_state = rsp_hit ? IDLE : (tmo ? FLUSH : WAIT_RSP);
      FLUSH:    next_state = flush_done ? IDLE : FLUSH;
      default:  next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  // Timer runs from issue through the response wait, and is reused to bound FLUSH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_waitrequest <= 1'b1;
      s_readdata <= '0;
      s_readdatavalid <= 1'b0;
      s_writeresponsevalid <= 1'b0;
      s_response <= 2'b00;
      m_address <= '0;
      m_read <= 1'b0;
      m_write <= 1'b0;
      m_byteenable <= '0;
      m_writedata <= '0;
      timeout_cnt <= '0;
      timer <= '0;
      is_wr <= 1'b0;
    end else begin
      s_waitrequest <= next_state != IDLE || fire;
      timer <= (cap || tmo) ? '0 : (state == IDLE ? timer : timer + 1'b1);
      s_readdatavalid <= fire && !is_wr;
      s_writeresponsevalid <= fire && is_wr;
      if (fire) s_response <= rsp_hit ? m_response : 2'b10;
      if (fire && !is_wr) s_readdata <= rsp_hit ? m_readdata : ERR_DATA;
      if (cap) begin
        m_address <= s_address;
        m_byteenable <= s_byteenable;
        m_writedata <= s_writedata;
        is_wr <= s_write;
      end
      m_read <= next_state == ISSUE && !op_wr;
      m_write <= next_state == ISSUE && op_wr;
      timeout_cnt <= timeout_cnt_clr ? '0 : (tmo && timeout_cnt != 16'hFFFF) ? timeout_cnt + 1'b1 : timeout_cnt;
    end
  end
endmodule

// File: tb/tb_avalon_mm_timeout_bridge.sv
// tb_avalon_mm_timeout_bridge: directed tests with a transaction-age reference model checked every cycle
module tb_avalon_mm_timeout_bridge;
  localparam int TC = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [11:0] s_address = '0;
  logic s_read = 1'b0, s_write = 1'b0;
  logic [3:0] s_byteenable = '0;
  logic [31:0] s_writedata = '0;
  logic s_waitrequest, s_readdatavalid, s_writeresponsevalid;
  logic [31:0] s_readdata;
  logic [1:0] s_response;
  logic [11:0] m_address;
  logic m_read, m_write;
  logic [3:0] m_byteenable;
  logic [31:0] m_writedata;
  logic m_waitrequest = 1'b0, m_readdatavalid = 1'b0, m_writeresponsevalid = 1'b0;
  logic [31:0] m_readdata = '0;
  logic [1:0] m_response = 2'b00;
  logic [15:0] timeout_cnt;
  logic timeout_cnt_clr = 1'b0;
  int n_chk = 0, n_pass = 0, cyc = 0;
  int ws = 0, rsp_lat = 2, rsp_cd = 0, cmd_cyc = 0, late_at = -1, preload_cyc = -1;
  bit stuck = 0, no_rsp = 0, rsp_wr = 0;

  avalon_mm_timeout_bridge #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(TC), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .s_writeresponsevalid(s_writeresponsevalid),
    .s_response(s_response),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .m_writeresponsevalid(m_writeresponsevalid),
    .m_response(m_response),
    .timeout_cnt(timeout_cnt), .timeout_cnt_clr(timeout_cnt_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
  endfunction

  // Downstream slave: waitrequest for ws cycles (or forever when stuck), response rsp_lat cycles after acceptance.
  always @(posedge clk) begin
    #1;
    m_readdatavalid = 1'b0;
    m_writeresponsevalid = 1'b0;
    if (rsp_cd > 0) begin
      rsp_cd--;
      if (rsp_cd == 0) begin
        if (rsp_wr) m_writeresponsevalid = 1'b1;
        else m_readdatavalid = 1'b1;
      end
    end
    if (cyc == late_at) m_readdatavalid = 1'b1;
    if (m_read || m_write) begin
      m_waitrequest = stuck || cmd_cyc < ws;
      if (m_waitrequest) cmd_cyc++;
      else begin
        cmd_cyc = 0;
        rsp_wr = m_write;
        if (!no_rsp) rsp_cd = rsp_lat;
      end
    end else begin
      m_waitrequest = stuck;
      cmd_cyc = 0;
    end
  end

  // Reference model: age = cycles since issue (-1 none), fage = cycles in flush (-1 none).
  int age = -1, fage = -1;
  bit acc = 0, op_wr = 0, strobe = 0;
  logic e_wait = 1'b1, e_rdv = 1'b0, e_wrv = 1'b0, e_mrd = 1'b0, e_mwr = 1'b0;
  logic [31:0] e_rdata = '0, e_wd = '0;
  logic [1:0] e_resp = '0;
  logic [11:0] e_addr = '0;
  logic [3:0] e_be = '0;
  logic [15:0] e_cnt = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      age = -1; fage = -1; acc = 0; op_wr = 0;
      e_wait = 1'b1; e_rdv = 1'b0; e_wrv = 1'b0; e_mrd = 1'b0; e_mwr = 1'b0;
      e_rdata = '0; e_wd = '0; e_resp = '0; e_addr = '0; e_be = '0; e_cnt = '0;
    end
    if (cyc == preload_cyc) e_cnt = 16'hFFFF;
    chk("s_waitrequest", 32'(s_waitrequest), 32'(e_wait));
    chk("s_readdatavalid", 32'(s_readdatavalid), 32'(e_rdv));
    chk("s_writeresponsevalid", 32'(s_writeresponsevalid), 32'(e_wrv));
    chk("s_readdata", s_readdata, e_rdata);
    chk("s_response", 32'(s_response), 32'(e_resp));
    chk("m_read", 32'(m_read), 32'(e_mrd));
    chk("m_write", 32'(m_write), 32'(e_mwr));
    chk("m_address", 32'(m_address), 32'(e_addr));
    chk("m_byteenable", 32'(m_byteenable), 32'(e_be));
    chk("m_writedata", m_writedata, e_wd);
    chk("timeout_cnt", 32'(timeout_cnt), 32'(e_cnt));
    if (rst_n) begin
      strobe = 0;
      if (age < 0 && fage < 0) begin
        if (!e_wait && (s_read || s_write)) begin
          op_wr = s_write; e_addr = s_address; e_be = s_byteenable; e_wd = s_writedata;
          acc = 0; age = 0;
        end
      end else if (age >= 0) begin
        if (acc && (op_wr ? m_writeresponsevalid : m_readdatavalid)) begin
          strobe = 1; e_resp = m_response;
          if (!op_wr) e_rdata = m_readdata;
          age = -1;
        end else if (age == TC - 1) begin
          strobe = 1; e_resp = 2'b10;
          if (!op_wr) e_rdata = ERR;
          if (e_cnt != 16'hFFFF) e_cnt++;
          age = -1; fage = 0;
        end else begin
          if (!m_waitrequest) acc = 1;
          age++;
        end
      end else fage = (m_readdatavalid || m_writeresponsevalid || fage == TC - 1) ? -1 : fage + 1;
      if (timeout_cnt_clr) e_cnt = '0;
      e_mrd = age >= 0 && !acc && !op_wr;
      e_mwr = age >= 0 && !acc && op_wr;
      e_rdv = strobe && !op_wr;
      e_wrv = strobe && op_wr;
      e_wait = age >= 0 || fage >= 0 || strobe;
    end
  end

  task automatic host(input bit rd, input bit wr, input logic [11:0] a, input logic [3:0] be,
                      input logic [31:0] wd, output int cap);
    @(posedge clk); #1;
    s_read = rd; s_write = wr; s_address = a; s_byteenable = be; s_writedata = wd;
    cap = -1;
    for (int i = 0; i < 200 && cap < 0; i++) begin
      @(negedge clk);
      if (!s_waitrequest) cap = cyc;
    end
    if (cap < 0) begin n_chk++; $display("FAIL host_accept at cycle %0d: got no accept, expected accept", cyc); end
    @(posedge clk); #1;
    s_read = 1'b0; s_write = 1'b0; s_address = '0; s_byteenable = '0; s_writedata = '0;
  endtask

  task automatic wait_strobe(input bit wr, output int at);
    at = -1;
    for (int i = 0; i < 60 && at < 0; i++) begin
      @(negedge clk);
      if (wr ? s_writeresponsevalid : s_readdatavalid) at = cyc;
    end
    if (at < 0) begin n_chk++; $display("FAIL strobe_wait at cycle %0d: got no strobe, expected strobe", cyc); end
  endtask

  task automatic wait_idle(output int at);
    at = -1;
    for (int i = 0; i < 60 && at < 0; i++) begin
      @(negedge clk);
      if (!s_waitrequest) at = cyc;
    end
    if (at < 0) begin n_chk++; $display("FAIL idle_wait at cycle %0d: got busy, expected idle", cyc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog at cycle %0d: got hang, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int cap, cap2, at, n, mr, mw, rdv;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); chk("rst_wait_hold", 32'(s_waitrequest), 1);
    @(negedge clk); chk("rst_wait_fall", 32'(s_waitrequest), 0);
    // Read with a two-cycle downstream response
    ws = 0; rsp_lat = 2; m_readdata = 32'h0000_00A5; m_response = 2'b00;
    host(1, 0, 12'h004, 4'hF, 32'h0, cap);
    wait_strobe(0, at);
    chk("rd_latency", at, cap + 4);
    chk("rd_data", s_readdata, 32'h0000_00A5);
    chk("rd_resp", 32'(s_response), 0);
    chk("rd_tcnt", 32'(timeout_cnt), 0);
    @(negedge clk); chk("rd_pulse_width", 32'(s_readdatavalid), 0);
    // Write with three waitrequest cycles
    ws = 3; rsp_lat = 1;
    host(0, 1, 12'h004, 4'hF, 32'h0000_003C, cap);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_write) n++; else break;
    end
    chk("wr_hold_cycles", n, 4);
    wait_strobe(1, at);
    chk("wr_latency", at, cap + 6);
    chk("wr_resp", 32'(s_response), 0);
    // Read timeout, late response swallowed, then a normal read
    ws = 0; no_rsp = 1;
    host(1, 0, 12'h010, 4'hF, 32'h0, cap);
    wait_strobe(0, at);
    chk("to_latency", at, cap + 17);
    chk("to_data", s_readdata, ERR);
    chk("to_resp", 32'(s_response), 2);
    chk("to_tcnt", 32'(timeout_cnt), 1);
    late_at = at + 5; no_rsp = 0; rsp_lat = 2; m_readdata = 32'h0000_1234;
    host(1, 0, 12'h014, 4'hF, 32'h0, cap2);
    chk("late_flush_exit", cap2, at + 6);
    wait_strobe(0, at);
    chk("after_to_latency", at, cap2 + 4);
    chk("after_to_data", s_readdata, 32'h0000_1234);
    chk("after_to_resp", 32'(s_response), 0);
    // Downstream waitrequest stuck high
    stuck = 1;
    host(1, 0, 12'h020, 4'hF, 32'h0, cap);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_read) n++; else break;
    end
    chk("stuck_mread_cycles", n, 16);
    chk("stuck_strobe", 32'(s_readdatavalid), 1);
    chk("stuck_strobe_cyc", cyc, cap + 17);
    chk("stuck_resp", 32'(s_response), 2);
    chk("stuck_tcnt", 32'(timeout_cnt), 2);
    wait_idle(at);
    chk("stuck_flush_len", at, cap + 33);
    stuck = 0;
    // Simultaneous read and write: the write wins
    rsp_lat = 1; m_readdata = 32'h0000_9999;
    host(1, 1, 12'h008, 4'h3, 32'h0000_0055, cap);
    mr = 0; mw = 0; rdv = 0; at = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_read) mr++;
      if (m_write) mw++;
      if (s_readdatavalid) rdv++;
      if (s_writeresponsevalid) at = cyc;
    end
    chk("rw_mread", mr, 0);
    chk("rw_mwrite", mw, 1);
    chk("rw_rdv", rdv, 0);
    chk("rw_wrv_cyc", at, cap + 3);
    // Reset while waiting for a response
    rsp_lat = 6; m_readdata = 32'h0000_0077;
    host(1, 0, 12'h00C, 4'hF, 32'h0, cap);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_mread", 32'(m_read), 0);
    chk("rst_mid_wait", 32'(s_waitrequest), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (s_readdatavalid || s_writeresponsevalid) n++;
    end
    chk("rst_no_strobe", n, 0);
    // Saturation and clear
    @(posedge clk); #1;
    force dut.timeout_cnt = 16'hFFFF;
    preload_cyc = cyc;
    #2 release dut.timeout_cnt;
    no_rsp = 1; rsp_lat = 2;
    host(1, 0, 12'h004, 4'hF, 32'h0, cap);
    wait_strobe(0, at);
    chk("sat_latency", at, cap + 17);
    chk("sat_tcnt", 32'(timeout_cnt), 32'h0000_FFFF);
    chk("sat_resp", 32'(s_response), 2);
    wait_idle(at);
    no_rsp = 0;
    @(posedge clk); #1 timeout_cnt_clr = 1'b1;
    @(negedge clk); chk("clr_pending", 32'(timeout_cnt), 32'h0000_FFFF);
    @(posedge clk); #1 timeout_cnt_clr = 1'b0;
    @(negedge clk); chk("clr_done", 32'(timeout_cnt), 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
